maf_abs_pipe: RTL and testbench
===============================

# maf_abs_pipe

Parametrised, pipelined sign-resolution and absolute-value stage for the multiply-add fused datapath. It sits after the adder and before normalisation. It takes the two's-complement adder result and the operand signs, and produces the result sign and the unsigned magnitude. Three packing modes are supported: full width, dual half-precision lanes, and truncated low field. The block is a 2-stage pipeline with a valid/ready handshake on both sides.

## Interface
Parameters:
- `W`, 75: adder result width; output magnitude is `W-1` bits.
- `HALF_W`, 36: lane width in split mode; requires `2*HALF_W+1 <= W-2`.
- `TRUNC_LSB`, 26: lowest live bit in truncated mode; bits below it are forced to 0.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: input beat valid.
- `in_ready`, output, 1: stage can accept a beat.
- `cont`, input, 3: mode select. 0 = full, 1 = split, 2 = truncated, 3..7 = illegal.
- `p_reg_temp`, input, `W`: two's-complement adder result.
- `S_A`, `S_B`, input, 1 each: operand signs for full mode and the low lane.
- `S_A_H`, `S_B_H`, input, 1 each: operand signs for the high lane.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: downstream accepts the result.
- `p_reg`, output, `W-1`: magnitude.
- `s2`, output, 1: result sign, full mode or low lane.
- `s2_h`, output, 1: high-lane result sign; 0 outside split mode.
- `mode_err`, output, 1: the beat carried an illegal `cont`.

## Operation
Sign of the sum per lane:
- Full mode and truncated mode: `s_a = p_reg_temp[W-1]`.
- Split mode, low lane: `s_a = p_reg_temp[HALF_W-1]`.
- Split mode, high lane: `s_a_h = p_reg_temp[2*HALF_W]`.

Result signs:
- `s2 = s_a ^ (S_A ^ S_B)`.
- `s2_h = s_a_h ^ (S_A_H ^ S_B_H)`.

Magnitude per lane is the field itself if its sign is 0, else the field's inversion plus 1, modulo the field width. The most-negative input wraps to itself; no saturation is applied.

Packing of `p_reg`:
- Mode 0: `p_reg = abs(p_reg_temp)[W-2:0]`.
- Mode 1:
  - Low lane field is `[HALF_W-1:0]`; high lane field is `[2*HALF_W:HALF_W+1]`.
  - `p_reg = {zeros, hi_mag[HALF_W-2:0], 1'b0, lo_mag[HALF_W-2:0]}`, zero-extended to `W-1` bits.
  - Input bit `HALF_W` and any bits above `2*HALF_W` are ignored.
- Mode 2: the field `[W-1:TRUNC_LSB]` is negated as a unit. `p_reg` takes that field's bits up to `W-2`, and bits below `TRUNC_LSB` are 0.
- Illegal mode: `p_reg = 0`, `s2 = s2_h = 0`, `mode_err = 1`. The beat still flows through the pipeline.

## Timing
Pipeline stages:
- Stage 1 registers `cont`, the per-lane `s_a`, the inverted or passed field, and the increment-needed bits.
- Stage 2 performs the +1 per lane, packs `p_reg`, and registers all outputs.
- Latency is exactly 2 cycles from input acceptance to `out_valid` when there is no stall.
- Throughput is one beat per cycle.

Handshake rules:
- A beat transfers on `in_valid & in_ready`, and on `out_valid & out_ready`.
- Stage 2 loads when `~out_valid | out_ready`.
- Stage 1 loads when it is empty or stage 2 loads.
- `in_ready = ~s1_valid | ~out_valid | out_ready`. This is combinational from `out_ready`.
- Outputs hold stable while `out_valid & ~out_ready`.
- Beats are never dropped or duplicated, and order is preserved.
- Mode may change on every beat; each beat carries its own `cont`.

Reset:
- Reset clears both stage valids.
- Reset values: `out_valid = 0`, `p_reg = 0`, `s2 = 0`, `s2_h = 0`, `mode_err = 0`. `in_ready` is 1 in the cycle after reset.
- Reset mid-stream discards in-flight beats. An input asserted in the reset cycle is not accepted.

## Configuration
`MAF_ABS_ZERO_FLAG_EN`:
- Defined: adds output `mag_zero [1:0]`, registered alongside `p_reg`.
  - Bit 0 = low-lane or full magnitude is 0.
  - Bit 1 = high-lane magnitude is 0 in split mode, else 0.
  - Reset value is 0.
- Undefined: the port and its logic are absent, and there is no other change.

## Structure
- Package `maf_pkg` holds the mode constants `CONT_FULL = 3'd0`, `CONT_SPLIT = 3'd1` and `CONT_TRUNC = 3'd2`, and the default `W`, `HALF_W` and `TRUNC_LSB` values.
- One sub-module, `maf_abs_lane`: parametrised width, conditional invert plus increment, instantiated for the low lane and the high lane. The full and truncated modes reuse the low-lane instance at full width.

## Test plan
- Mode 0 sign behaviour: `p_reg_temp` all ones, `S_A = S_B = 0` -> after 2 cycles `p_reg = 1`, `s2 = 1`, `s2_h = 0`.
- Mode 1 lane packing: low field `36'hF_FFFF_FFFE`, high field `36'h5`, `S_A_H = 1`, `S_B_H = 0`, `S_A = S_B = 0` -> `p_reg = {3'b0, 35'd5, 1'b0, 35'd2}`, `s2 = 1`, `s2_h = 1`.
- Mode 2 truncation: `p_reg_temp[74:26] = -3`, low bits random -> `p_reg = 3 << 26`, low 26 bits 0, `s2 = 1`.
- Backpressure: hold `out_ready = 0` and offer 4 back-to-back beats -> exactly 2 accepted and `in_ready` falls. Release `out_ready` -> all 4 results emerge in order with no gaps.
- Illegal mode and reset: `cont = 5` -> `mode_err = 1`, `p_reg = 0`. Assert `rst` with 2 beats in flight -> next cycle `out_valid = 0` and all outputs 0.
- With `MAF_ABS_ZERO_FLAG_EN` defined: full-mode input 0 gives `mag_zero = 2'b01`. Split mode with both lanes 0 gives `2'b11`.

Source files
------------

// File: rtl/maf_pkg.sv
// Shared mode encodings and default geometry for the multiply-add fused
// absolute-value stage.
package maf_pkg;

  localparam logic [2:0] CONT_FULL  = 3'd0;
  localparam logic [2:0] CONT_SPLIT = 3'd1;
  localparam logic [2:0] CONT_TRUNC = 3'd2;

  localparam int MAF_W         = 75;
  localparam int MAF_HALF_W    = 36;
  localparam int MAF_TRUNC_LSB = 26;

endpackage

// File: rtl/maf_abs_lane.sv
// One lane of conditional two's-complement negation, split across the two
// pipeline stages: invert is registered here, the +1 is applied downstream.
module maf_abs_lane #(
  parameter int N = 36
) (
  input  logic         clk,
  input  logic         load,
  input  logic [N-1:0] field,
  input  logic         neg,
  output logic [N-1:0] mag
);

  logic [N-1:0] inv_q;
  logic         inc_q;

  always_ff @(posedge clk) begin
    if (load) begin
      inv_q <= field ^ {N{neg}};
      inc_q <= neg;
    end
  end

  assign mag = inv_q + {{(N-1){1'b0}}, inc_q};

endmodule

// File: rtl/maf_abs_pipe.sv
// Two-stage sign resolution / absolute value after the fused adder.
// Optional MAF_ABS_ZERO_FLAG_EN adds a registered mag_zero[1:0] output.
module maf_abs_pipe
  import maf_pkg::*;
#(
  parameter int W         = MAF_W,
  parameter int HALF_W    = MAF_HALF_W,
  parameter int TRUNC_LSB = MAF_TRUNC_LSB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   cont,
  input  logic [W-1:0] p_reg_temp,
  input  logic         S_A,
  input  logic         S_B,
  input  logic         S_A_H,
  input  logic         S_B_H,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-2:0] p_reg,
  output logic         s2,
  output logic         s2_h,
  output logic         mode_err
`ifdef MAF_ABS_ZERO_FLAG_EN
  ,
  output logic [1:0]   mag_zero
`endif
);

  logic s1_valid, ld1, ld2, accept;

  assign ld2      = ~out_valid | out_ready;
  assign ld1      = ~s1_valid | ld2;
  assign in_ready = ld1;
  assign accept   = in_valid & in_ready;

  // The low-lane instance runs at full width; split and truncated fields are
  // zero-padded so the same negation yields the right low/high bits.
  logic [W-1:0] lo_field;
  logic         s_a_d, s_a_h_d;

  always_comb begin
    lo_field = '0;
    s_a_d    = 1'b0;
    case (cont)
      CONT_FULL: begin
        lo_field = p_reg_temp;
        s_a_d    = p_reg_temp[W-1];
      end
      CONT_SPLIT: begin
        lo_field[HALF_W-1:0] = p_reg_temp[HALF_W-1:0];
        s_a_d                = p_reg_temp[HALF_W-1];
      end
      CONT_TRUNC: begin
        lo_field[W-1:TRUNC_LSB] = p_reg_temp[W-1:TRUNC_LSB];
        s_a_d                   = p_reg_temp[W-1];
      end
      default: ;
    endcase
  end

  assign s_a_h_d = (cont == CONT_SPLIT) & p_reg_temp[2*HALF_W];

  logic [2:0] cont_q;
  logic       s_a_q, s_a_h_q, sx_q, sx_h_q;

  always_ff @(posedge clk) begin
    if (rst)      s1_valid <= 1'b0;
    else if (ld1) s1_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cont_q  <= cont;
      s_a_q   <= s_a_d;
      s_a_h_q <= s_a_h_d;
      sx_q    <= S_A ^ S_B;
      sx_h_q  <= S_A_H ^ S_B_H;
    end
  end

  logic [W-1:0]      lo_mag;
  logic [HALF_W-1:0] hi_mag;

  maf_abs_lane #(.N(W)) u_lo (
    .clk   (clk),
    .load  (accept),
    .field (lo_field),
    .neg   (s_a_d),
    .mag   (lo_mag)
  );

  maf_abs_lane #(.N(HALF_W)) u_hi (
    .clk   (clk),
    .load  (accept),
    .field (p_reg_temp[2*HALF_W:HALF_W+1]),
    .neg   (s_a_h_d),
    .mag   (hi_mag)
  );

  logic [W-2:0] p_next;
  logic         s2_next, s2_h_next, err_next;

  always_comb begin
    p_next    = '0;
    s2_next   = 1'b0;
    s2_h_next = 1'b0;
    err_next  = 1'b0;
    case (cont_q)
      CONT_FULL, CONT_TRUNC: begin
        p_next  = lo_mag[W-2:0];
        s2_next = s_a_q ^ sx_q;
      end
      CONT_SPLIT: begin
        p_next    = {{(W-2*HALF_W){1'b0}}, hi_mag[HALF_W-2:0], 1'b0, lo_mag[HALF_W-2:0]};
        s2_next   = s_a_q ^ sx_q;
        s2_h_next = s_a_h_q ^ sx_h_q;
      end
      default: err_next = 1'b1;
    endcase
  end

  // Top bits of each lane never reach p_reg; kept out of lint reports.
  logic unused_mag_bits;
  assign unused_mag_bits = ^{lo_mag[W-1], hi_mag[HALF_W-1]};

`ifdef MAF_ABS_ZERO_FLAG_EN
  logic [1:0] zf_next;

  always_comb begin
    zf_next = 2'b00;
    case (cont_q)
      CONT_FULL, CONT_TRUNC: zf_next[0] = (p_next == '0);
      CONT_SPLIT: begin
        zf_next[0] = (lo_mag[HALF_W-1:0] == '0);
        zf_next[1] = (hi_mag == '0);
      end
      default: ;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      p_reg     <= '0;
      s2        <= 1'b0;
      s2_h      <= 1'b0;
      mode_err  <= 1'b0;
`ifdef MAF_ABS_ZERO_FLAG_EN
      mag_zero  <= 2'b00;
`endif
    end else if (ld2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        p_reg    <= p_next;
        s2       <= s2_next;
        s2_h     <= s2_h_next;
        mode_err <= err_next;
`ifdef MAF_ABS_ZERO_FLAG_EN
        mag_zero <= zf_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_maf_abs_pipe.sv
// Scoreboard bench for maf_abs_pipe: directed beats push expectations, a
// negedge monitor pops and compares every transferred result.
module tb_maf_abs_pipe;

  localparam int W         = 75;
  localparam int HALF_W    = 36;
  localparam int TRUNC_LSB = 26;

  typedef struct packed {
    logic [W-2:0] p;
    logic         s2;
    logic         s2h;
    logic         err;
    logic [1:0]   mz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [2:0]   cont;
  logic [W-1:0] p_reg_temp;
  logic         S_A, S_B, S_A_H, S_B_H;
  logic [W-2:0] p_reg;
  logic         s2, s2_h, mode_err;
  logic [1:0]   mz_obs;
  logic [1:0]   mz_mask;

`ifdef MAF_ABS_ZERO_FLAG_EN
  logic [1:0] mag_zero;
  assign mz_obs  = mag_zero;
  assign mz_mask = 2'b11;
`else
  assign mz_obs  = 2'b00;
  assign mz_mask = 2'b00;
`endif

  maf_abs_pipe #(.W(W), .HALF_W(HALF_W), .TRUNC_LSB(TRUNC_LSB)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cont       (cont),
    .p_reg_temp (p_reg_temp),
    .S_A        (S_A),
    .S_B        (S_B),
    .S_A_H      (S_A_H),
    .S_B_H      (S_B_H),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .p_reg      (p_reg),
    .s2         (s2),
    .s2_h       (s2_h),
    .mode_err   (mode_err)
`ifdef MAF_ABS_ZERO_FLAG_EN
    ,
    .mag_zero   (mag_zero)
`endif
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t mk(input logic [W-2:0] p, input logic a, input logic b,
                              input logic e, input logic [1:0] z);
    exp_t r;
    r.p   = p;
    r.s2  = a;
    r.s2h = b;
    r.err = e;
    r.mz  = z;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic setBeat(input logic [2:0] c, input logic [W-1:0] d,
                         input logic sa, input logic sb_, input logic sah, input logic sbh);
    cont       = c;
    p_reg_temp = d;
    S_A        = sa;
    S_B        = sb_;
    S_A_H      = sah;
    S_B_H      = sbh;
  endtask

  task automatic applyStimulus(input logic [2:0] c, input logic [W-1:0] d,
                               input logic sa, input logic sb_, input logic sah, input logic sbh,
                               input exp_t e);
    int waited = 0;
    setBeat(c, d, sa, sb_, sah, sbh);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) checkOutput("accept_timeout", 128'(in_ready), 128'd1);
    else sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every transfer on the output side is matched against the queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_beat", 128'(out_valid), 128'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("result", {p_reg, s2, s2_h, mode_err, mz_obs},
                    {e.p, e.s2, e.s2h, e.err, e.mz & mz_mask});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] bp_d[4];
    exp_t         bp_e[4];
    logic [W-1:0] d;
    logic         lat0, lat1;
    int           accepted, run, seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    setBeat(3'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_outputs", {out_valid, p_reg, s2, s2_h, mode_err, mz_obs}, 128'd0);
    checkOutput("reset_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;

    // Mode 0, all ones: latency and sign
    setBeat(3'd0, '1, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    if (in_ready) sb.push_back(mk(74'd1, 1'b1, 1'b0, 1'b0, 2'b00));
    checkOutput("first_accept", 128'(in_ready), 128'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk) lat0 = out_valid;
    @(posedge clk); #1;
    @(negedge clk) lat1 = out_valid;
    checkOutput("latency", {lat0, lat1}, 128'b01);
    @(posedge clk); #1;

    applyStimulus(3'd0, 75'd12345, 1'b1, 1'b1, 1'b0, 1'b0, mk(74'd12345, 1'b0, 1'b0, 1'b0, 2'b00));
    applyStimulus(3'd0, {1'b1, 74'd0}, 1'b0, 1'b1, 1'b0, 1'b0, mk(74'd0, 1'b0, 1'b0, 1'b0, 2'b01));
    applyStimulus(3'd0, 75'd0, 1'b0, 1'b1, 1'b0, 1'b0, mk(74'd0, 1'b1, 1'b0, 1'b0, 2'b01));

    applyStimulus(3'd1, {2'b11, 36'h0_0000_0005, 1'b1, 36'hF_FFFF_FFFE}, 1'b0, 1'b0, 1'b1, 1'b0,
                  mk({3'b0, 35'd5, 1'b0, 35'd2}, 1'b1, 1'b1, 1'b0, 2'b00));
    applyStimulus(3'd1, {2'b00, 36'hF_FFFF_FFF9, 1'b0, 36'h0_0000_0003}, 1'b1, 1'b1, 1'b1, 1'b1,
                  mk({3'b0, 35'd7, 1'b0, 35'd3}, 1'b0, 1'b1, 1'b0, 2'b00));
    applyStimulus(3'd1, {2'b10, 36'h0, 1'b1, 36'h0}, 1'b0, 1'b0, 1'b1, 1'b0,
                  mk(74'd0, 1'b0, 1'b1, 1'b0, 2'b11));

    d = {49'h1_FFFF_FFFF_FFFD, 26'($urandom)};
    applyStimulus(3'd2, d, 1'b0, 1'b0, 1'b0, 1'b0, mk(74'd3 << 26, 1'b1, 1'b0, 1'b0, 2'b00));
    d = {49'd9, 26'($urandom)};
    applyStimulus(3'd2, d, 1'b0, 1'b1, 1'b0, 1'b0, mk(74'd9 << 26, 1'b1, 1'b0, 1'b0, 2'b00));

    applyStimulus(3'd5, '1, 1'b1, 1'b0, 1'b1, 1'b0, mk(74'd0, 1'b0, 1'b0, 1'b1, 2'b00));
    applyStimulus(3'd3, 75'd77, 1'b0, 1'b1, 1'b0, 1'b1, mk(74'd0, 1'b0, 1'b0, 1'b1, 2'b00));

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;

    // Backpressure: only two beats fit while the output is stalled
    bp_d[0] = 75'd1007;         bp_e[0] = mk(74'd1007, 1'b0, 1'b0, 1'b0, 2'b00);
    bp_d[1] = 75'd2007;         bp_e[1] = mk(74'd2007, 1'b0, 1'b0, 1'b0, 2'b00);
    bp_d[2] = 75'd0 - 75'd50;   bp_e[2] = mk(74'd50,   1'b1, 1'b0, 1'b0, 2'b00);
    bp_d[3] = 75'd4007;         bp_e[3] = mk(74'd4007, 1'b0, 1'b0, 1'b0, 2'b00);
    out_ready = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 4; i++) begin
      setBeat(3'd0, bp_d[accepted], 1'b0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(bp_e[accepted]);
        accepted++;
      end
      @(posedge clk); #1;
    end
    checkOutput("bp_accepted", 128'(accepted), 128'd2);
    checkOutput("bp_in_ready_low", 128'(in_ready), 128'd0);
    out_ready = 1'b1;
    run = 0;
    for (int i = 0; i < 4; i++) begin
      if (accepted < 4) begin
        setBeat(3'd0, bp_d[accepted], 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid) run++;
      if (in_valid && in_ready) begin
        sb.push_back(bp_e[accepted]);
        accepted++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checkOutput("bp_all_accepted", 128'(accepted), 128'd4);
    checkOutput("bp_no_gap", 128'(run), 128'd4);

    // Reset with two beats in flight and a beat offered during reset
    out_ready = 1'b0;
    applyStimulus(3'd0, '1, 1'b0, 1'b0, 1'b0, 1'b0, mk(74'd1, 1'b1, 1'b0, 1'b0, 2'b00));
    applyStimulus(3'd0, '1, 1'b0, 1'b0, 1'b0, 1'b0, mk(74'd1, 1'b1, 1'b0, 1'b0, 2'b00));
    setBeat(3'd0, 75'd99, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    checkOutput("rst_mid_outputs", {out_valid, p_reg, s2, s2_h, mode_err, mz_obs}, 128'd0);
    checkOutput("rst_mid_in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("rst_no_accept", 128'(seen), 128'd0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    checkOutput("drain", 128'(sb.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
